// File: rtl/c6502_bus.sv
// c6502_bus -- bus sequencer between a 6502-style CPU core and its memories.
//
// The CPU core is clock-enabled: it presents an address/write strobe and
// waits until cpu_ce pulses for one cycle. That pulse marks the end of the
// bus cycle, and read data is valid on cpu_in in that same cycle.
//   0000-7FFF : internal synchronous RAM. One-cycle read latency.
//               The bus cycle is always 2 clocks.
//   8000-FFFF : external req/ack port. The bus cycle is at least 3 clocks.
//
// Ports
//   clock, reset           : single clock; synchronous active-high reset
//   cpu_address/out/we     : CPU request, held stable while cpu_ce=0
//   cpu_in, cpu_ce         : read data and one-cycle completion pulse
//   ram_address/out/we/in  : synchronous RAM port
//   ext_req/we/address/wdata, ext_rdata/ack : external request/acknowledge port
//   bus_err                : sticky external-timeout flag
//
// Configuration
//   TIMEOUT                : watchdog limit in S_EXT cycles (8-bit)
//   `C6502_BUS_TIMEOUT_EN  : when defined, adds the external-access watchdog.
//                            When undefined, S_EXT waits indefinitely and
//                            bus_err is tied to 0.
module c6502_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_ce,
  output logic [14:0] ram_address,
  output logic [7:0]  ram_out,
  output logic        ram_we,
  input  logic [7:0]  ram_in,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_address,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_ADDR, S_RAM, S_EXT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [15:0] ext_address_q, ext_address_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic [7:0]  rdata_q, rdata_d;     // data latched from the external port
  logic [7:0]  cpu_in_q, cpu_in_d;   // last value shown on cpu_in

`ifdef C6502_BUS_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
  logic [7:0] wd_q, wd_d;
  logic       bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    ext_req_d     = ext_req_q;
    ext_we_d      = ext_we_q;
    ext_address_d = ext_address_q;
    ext_wdata_d   = ext_wdata_q;
    rdata_d       = rdata_q;
    ram_address   = cpu_address[14:0];
    ram_out       = cpu_out;
    ram_we        = 1'b0;
    cpu_ce        = 1'b0;
    cpu_in        = cpu_in_q;
`ifdef C6502_BUS_TIMEOUT_EN
    wd_d          = wd_q;
    bus_err_d     = bus_err_q;
`endif

    unique case (state_q)
      S_ADDR: begin
        if (!cpu_address[15]) begin
          // The RAM write strobe comes straight from the CPU for this single
          // cycle. Reset masks it so that a write in flight never lands.
          ram_we  = cpu_we & ~reset;
          state_d = S_RAM;
        end else begin
          ext_address_d = cpu_address;
          ext_wdata_d   = cpu_out;
          ext_we_d      = cpu_we;
          ext_req_d     = 1'b1;
          state_d       = S_EXT;
`ifdef C6502_BUS_TIMEOUT_EN
          wd_d          = 8'd0;
`endif
        end
      end

      S_RAM: begin
        cpu_ce  = 1'b1;
        cpu_in  = ram_in;
        state_d = S_ADDR;
      end

      S_EXT: begin
        // Ack is checked first, so it wins when it coincides with the
        // watchdog expiring.
        if (ext_ack) begin
          rdata_d   = ext_we_q ? 8'hFF : ext_rdata;
          ext_req_d = 1'b0;
          state_d   = S_DONE;
        end
`ifdef C6502_BUS_TIMEOUT_EN
        else if (({1'b0, wd_q} + 9'd1) == TIMEOUT_LIM) begin
          rdata_d   = 8'hFF;
          ext_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end

      S_DONE: begin
        cpu_ce  = 1'b1;
        cpu_in  = rdata_q;
        state_d = S_ADDR;
      end

      default: state_d = S_ADDR;
    endcase

    // Never hand the CPU a completion while reset is being applied.
    if (reset) cpu_ce = 1'b0;
    cpu_in_d = cpu_ce ? cpu_in : cpu_in_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_ADDR;
      ext_req_q     <= 1'b0;
      ext_we_q      <= 1'b0;
      ext_address_q <= 16'h0000;
      ext_wdata_q   <= 8'h00;
      rdata_q       <= 8'h00;
      cpu_in_q      <= 8'h00;
`ifdef C6502_BUS_TIMEOUT_EN
      wd_q          <= 8'd0;
      bus_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ext_req_q     <= ext_req_d;
      ext_we_q      <= ext_we_d;
      ext_address_q <= ext_address_d;
      ext_wdata_q   <= ext_wdata_d;
      rdata_q       <= rdata_d;
      cpu_in_q      <= cpu_in_d;
`ifdef C6502_BUS_TIMEOUT_EN
      wd_q          <= wd_d;
      bus_err_q     <= bus_err_d;
`endif
    end
  end

  assign ext_req     = ext_req_q;
  assign ext_we      = ext_we_q;
  assign ext_address = ext_address_q;
  assign ext_wdata   = ext_wdata_q;

`ifdef C6502_BUS_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule
